button_event_decoder: RTL and testbench

- Consumes the synchronous, debounced level produced by the debouncer and turns it into one-clock event strobes for the stopwatch control logic: press, release, long-press and auto-repeat.
- Also reports the held state and the hold duration in ticks.
- Shares the debouncer's sample-rate strobe, so all timing is in sample ticks (1 ms at defaults).

---
 rtl/button_event_decoder_pkg.sv | 10 +
 rtl/btn_hold_timer.sv | 34 +++
 rtl/button_event_decoder.sv | 69 ++++++
 tb/tb_button_event_decoder.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/button_event_decoder_pkg.sv
// button_event_decoder_pkg: decoder state encoding and per-button timing defaults
package button_event_decoder_pkg;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHORT = 2'd1;
  localparam logic [1:0] ST_LONG  = 2'd2;
  localparam int START_LONG_PRESS_TICKS    = 1000;
  localparam int START_REPEAT_PERIOD_TICKS = 0;
  localparam int LAP_LONG_PRESS_TICKS      = 1000;
  localparam int LAP_REPEAT_PERIOD_TICKS   = 200;
endpackage

// File: rtl/btn_hold_timer.sv
// btn_hold_timer: saturating hold counter plus wrapping repeat counter with threshold flags
module btn_hold_timer #(
  parameter int LONG_PRESS_TICKS    = 1000,
  parameter int REPEAT_PERIOD_TICKS = 200,
  parameter int COUNT_WIDTH         = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tick,
  input  logic                   clear,
  input  logic                   run,
  output logic [COUNT_WIDTH-1:0] hold,
  output logic                   long_hit,
  output logic                   rpt_hit
);
  localparam logic [COUNT_WIDTH-1:0] MAX     = '1;
  localparam logic [COUNT_WIDTH-1:0] LONG_M1 = COUNT_WIDTH'(LONG_PRESS_TICKS - 1);
  localparam logic [COUNT_WIDTH-1:0] RPT_M1  = COUNT_WIDTH'(REPEAT_PERIOD_TICKS - 1);
  logic [COUNT_WIDTH-1:0] rpt;
  assign long_hit = hold == LONG_M1;
  assign rpt_hit  = (REPEAT_PERIOD_TICKS != 0) && (rpt == RPT_M1);
  // The repeat phase restarts on the tick that crosses into a long press.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      hold <= '0;
      rpt  <= '0;
    end else if (clear) begin
      hold <= '0;
      rpt  <= '0;
    end else if (run && tick) begin
      hold <= (hold == MAX) ? hold : hold + COUNT_WIDTH'(1);
      rpt  <= (long_hit || rpt_hit) ? '0 : rpt + COUNT_WIDTH'(1);
    end
endmodule

// File: rtl/button_event_decoder.sv
// button_event_decoder: turns a debounced button level into press/release/long/repeat strobes
// release_evt/repeat_evt carry the release/repeat strobes; both plain names are SV keywords.
module button_event_decoder
  import button_event_decoder_pkg::*;
#(
  parameter int LONG_PRESS_TICKS    = 1000,
  parameter int REPEAT_PERIOD_TICKS = 200,
  parameter int COUNT_WIDTH         = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tick,
  input  logic                   in,
  input  logic                   enable,
  output logic                   press,
  output logic                   release_evt,
  output logic                   long_press,
  output logic                   repeat_evt,
  output logic                   held,
  output logic [COUNT_WIDTH-1:0] hold_ticks
);
  logic [1:0] state, state_nx;
  logic in_q, armed, rise, fall, start, rel_go, long_go, rpt_go, run, long_hit, rpt_hit;
  always_comb begin
    rise     = armed & in & ~in_q;
    fall     = armed & ~in & in_q;
    start    = enable & (state == ST_IDLE) & rise;
    rel_go   = enable & (state != ST_IDLE) & fall;
    run      = enable & (state != ST_IDLE) & ~fall;
    long_go  = run & tick & (state == ST_SHORT) & long_hit;
    rpt_go   = run & tick & (state == ST_LONG) & rpt_hit;
    state_nx = (!enable || rel_go) ? ST_IDLE : start ? ST_SHORT : long_go ? ST_LONG : state;
  end
  btn_hold_timer #(
    .LONG_PRESS_TICKS(LONG_PRESS_TICKS),
    .REPEAT_PERIOD_TICKS(REPEAT_PERIOD_TICKS),
    .COUNT_WIDTH(COUNT_WIDTH)
  ) u_timer (
    .clk(clk),
    .rst(rst),
    .tick(tick),
    .clear(start),
    .run(run),
    .hold(hold_ticks),
    .long_hit(long_hit),
    .rpt_hit(rpt_hit)
  );
  // armed masks the first sample after reset so a held button cannot fake a rising edge.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state       <= ST_IDLE;
      in_q        <= 1'b0;
      armed       <= 1'b0;
      press       <= 1'b0;
      release_evt <= 1'b0;
      long_press  <= 1'b0;
      repeat_evt  <= 1'b0;
      held        <= 1'b0;
    end else begin
      state       <= state_nx;
      in_q        <= in;
      armed       <= 1'b1;
      press       <= start;
      release_evt <= rel_go;
      long_press  <= long_go;
      repeat_evt  <= rpt_go;
      held        <= state_nx != ST_IDLE;
    end
endmodule

// File: tb/tb_button_event_decoder.sv
// tb_button_event_decoder: two decoder configs driven in parallel, checked against a tick-count model
module tb_button_event_decoder;
  logic clk = 1'b0, rst = 1'b1, tick = 1'b0, in = 1'b0, enable = 1'b1;
  logic p0, r0, l0, q0, h0;
  logic [7:0] t0;
  logic p1, r1, l1, q1, h1;
  logic [3:0] t1;
  int n_cmp = 0, n_bad = 0, phase = 0;
  int c_press[2] = '{0, 0}, c_rel[2] = '{0, 0}, c_long[2] = '{0, 0}, c_rpt[2] = '{0, 0};
  localparam int L = 5;
  int per[2] = '{3, 0};
  int maxh[2] = '{255, 15};
  bit m_armed = 0, m_in_q = 0;
  bit m_act[2] = '{0, 0};
  int m_n[2] = '{0, 0};
  logic [12:0] exp_v[2] = '{13'd0, 13'd0};
  always #5 clk = ~clk;
  button_event_decoder #(.LONG_PRESS_TICKS(5), .REPEAT_PERIOD_TICKS(3), .COUNT_WIDTH(8)) dut0 (
    .clk(clk), .rst(rst), .tick(tick), .in(in), .enable(enable),
    .press(p0), .release_evt(r0), .long_press(l0), .repeat_evt(q0), .held(h0), .hold_ticks(t0));
  button_event_decoder #(.LONG_PRESS_TICKS(5), .REPEAT_PERIOD_TICKS(0), .COUNT_WIDTH(4)) dut1 (
    .clk(clk), .rst(rst), .tick(tick), .in(in), .enable(enable),
    .press(p1), .release_evt(r1), .long_press(l1), .repeat_evt(q1), .held(h1), .hold_ticks(t1));
  // Model: a press is active/inactive plus an unbounded count of ticks held.
  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      m_armed = 0;
      m_in_q = 0;
      for (int k = 0; k < 2; k++) begin
        m_act[k] = 0;
        m_n[k] = 0;
        exp_v[k] = '0;
      end
    end else begin
      bit rise, fall;
      rise = m_armed && in && !m_in_q;
      fall = m_armed && !in && m_in_q;
      for (int k = 0; k < 2; k++) begin
        bit ps, rl, lg, rp;
        ps = 0; rl = 0; lg = 0; rp = 0;
        if (!enable) m_act[k] = 0;
        else if (!m_act[k]) begin
          if (rise) begin m_act[k] = 1; m_n[k] = 0; ps = 1; end
        end else if (fall) begin m_act[k] = 0; rl = 1; end
        else if (tick) begin
          m_n[k]++;
          lg = m_n[k] == L;
          rp = per[k] != 0 && m_n[k] > L && (m_n[k] - L) % per[k] == 0;
        end
        exp_v[k] = {ps, rl, lg, rp, m_act[k], 8'(m_n[k] > maxh[k] ? maxh[k] : m_n[k])};
      end
      m_in_q = in;
      m_armed = 1;
    end
  end
  initial forever begin
    logic [12:0] got[2];
    @(negedge clk);
    got[0] = {p0, r0, l0, q0, h0, t0};
    got[1] = {p1, r1, l1, q1, h1, 4'b0, t1};
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (got[k] !== exp_v[k]) begin
        n_bad++;
        $display("FAIL model dut%0d t=%0t: got p/r/l/q/h/hold=%b expected %b", k, $time, got[k], exp_v[k]);
      end
      c_press[k] += int'(got[k][12]);
      c_rel[k]   += int'(got[k][11]);
      c_long[k]  += int'(got[k][10]);
      c_rpt[k]   += int'(got[k][9]);
    end
  end
  task automatic chk(input string nm, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask
  task automatic cyc(input logic i, input logic e);
    @(negedge clk);
    #1;
    in = i;
    enable = e;
    tick = phase == 3;
    phase = (phase + 1) % 4;
  endtask
  task automatic run_ticks(input int n);
    int t = 0;
    while (t < n) begin
      cyc(1'b1, 1'b1);
      if (tick) t++;
    end
  endtask
  task automatic start_press(output int t);
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b1);
    t = int'(tick);
  endtask
  initial begin
    int t, bp, br, bl, bq, bl1, bq1;
    logic i;
    #2 rst = 1'b0;
    repeat (3) cyc(1'b0, 1'b1);
    chk("reset_outputs", int'({p0, r0, l0, q0, h0, t0}), 0);
    rst = 1'b1;
    // 1: short press of two ticks
    repeat (9) cyc(1'b0, 1'b1);
    bl = c_long[0];
    cyc(1'b1, 1'b1);
    chk("no_press_before_edge", int'(p0), 0);
    cyc(1'b1, 1'b1);
    chk("press_latency", int'(p0), 1);
    chk("held_with_press", int'(h0), 1);
    t = int'(tick);
    run_ticks(2 - t);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);
    chk("release_strobe", int'(r0), 1);
    chk("short_hold_ticks", int'(t0), 2);
    chk("short_no_long", c_long[0] - bl, 0);
    // 2: long press with repeats, hold persists after release
    repeat (3) cyc(1'b0, 1'b1);
    bl = c_long[0]; bq = c_rpt[0]; bq1 = c_rpt[1];
    start_press(t);
    run_ticks(5 - t);
    cyc(1'b1, 1'b1);
    chk("long_strobe", int'(l0), 1);
    chk("long_hold_ticks", int'(t0), 5);
    run_ticks(7);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);
    chk("long_release", int'(r0), 1);
    chk("hold_after_release", int'(t0), 12);
    chk("repeat_count", c_rpt[0] - bq, 2);
    chk("long_count", c_long[0] - bl, 1);
    chk("no_repeat_when_disabled", c_rpt[1] - bq1, 0);
    repeat (5) cyc(1'b0, 1'b1);
    chk("hold_persists", int'(t0), 12);
    // 4: fall on the threshold tick
    bl = c_long[0]; br = c_rel[0];
    start_press(t);
    run_ticks(4 - t);
    while (phase != 3) cyc(1'b1, 1'b1);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);
    chk("fall_wins_release", c_rel[0] - br, 1);
    chk("fall_wins_no_long", c_long[0] - bl, 0);
    chk("fall_wins_hold", int'(t0), 4);
    cyc(1'b0, 1'b1);
    chk("fall_wins_idle", int'(h0), 0);
    // 5: enable drop during long press
    start_press(t);
    run_ticks(6 - t);
    br = c_rel[0]; bq = c_rpt[0]; bp = c_press[0];
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    chk("disable_held", int'(h0), 0);
    repeat (12) cyc(1'b1, 1'b0);
    repeat (8) cyc(1'b1, 1'b1);
    chk("disable_no_release", c_rel[0] - br, 0);
    chk("disable_no_repeat", c_rpt[0] - bq, 0);
    chk("reenable_no_press", c_press[0] - bp, 0);
    cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b1);
    chk("reenable_press", int'(p0), 1);
    cyc(1'b0, 1'b1);
    repeat (3) cyc(1'b0, 1'b1);
    // 6: saturation of the narrow config, repeats on the wide one
    bl1 = c_long[1]; bq1 = c_rpt[1]; bq = c_rpt[0];
    start_press(t);
    run_ticks(20 - t);
    cyc(1'b1, 1'b1);
    chk("saturate_hold4", int'(t1), 15);
    chk("wide_hold20", int'(t0), 20);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);
    chk("sat_one_long", c_long[1] - bl1, 1);
    chk("sat_zero_repeat", c_rpt[1] - bq1, 0);
    chk("wide_repeat_count", c_rpt[0] - bq, 5);
    // 3: button held through reset
    cyc(1'b1, 1'b1);
    rst = 1'b0;
    repeat (3) cyc(1'b1, 1'b1);
    chk("reset_mid_held", int'(h0), 0);
    rst = 1'b1;
    bp = c_press[0];
    repeat (8) cyc(1'b1, 1'b1);
    chk("held_through_reset", c_press[0] - bp, 0);
    cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b1);
    chk("press_after_reset", int'(p0), 1);
    repeat (4) cyc(1'b1, 1'b1);
    chk("single_press", c_press[0] - bp, 1);
    // random traffic, model-checked every cycle
    i = 1'b0;
    repeat (5000) begin
      if ($urandom_range(0, 11) == 0) i = ~i;
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b0;
        cyc(i, 1'b1);
        rst = 1'b1;
      end
      cyc(i, $urandom_range(0, 49) != 0);
    end
    repeat (4) cyc(1'b0, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
